write_accounter: RTL and testbench

Write-side counterpart of the bank read switch in the multi-write/multi-read BRAM.
- Registers write agents' requests toward their private banks: write agent k owns bank k.
- Keeps a per-address table recording which bank holds the most recent data and whether a write collision occurred.
- For each read agent, produces the bank_select word that the read switch consumes.

---
 rtl/meduram_pkg.sv | 48 ++++
 rtl/write_collision_detect.sv | 39 +++
 rtl/write_accounter.sv | 92 +++++++++
 tb/tb_write_accounter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/meduram_pkg.sv
// Shared types and helpers for the multi-write/multi-read BRAM accounting logic.
package meduram_pkg;

    localparam int MAX_AGENTS = 32;
    localparam int MAX_ADDR_W = 10;
    localparam int MAX_BANK_W = 5;
    localparam int MAX_SEL_W  = MAX_BANK_W + 1;

    typedef struct packed {
        logic                  coll;
        logic [MAX_BANK_W-1:0] bank;
    } entry_t;

    function automatic int select_width(input int n, input int wc);
        return ((n == 1) ? 1 : $clog2(n)) + wc;
    endfunction

    // Highest enabled agent index among the first n agents targeting address a; -1 if none.
    function automatic int highest_match(
        input logic [MAX_AGENTS-1:0]                 en,
        input logic [MAX_AGENTS-1:0][MAX_ADDR_W-1:0] addrs,
        input logic [MAX_ADDR_W-1:0]                 a,
        input int                                    n
    );
        int w;
        w = -1;
        for (int k = 0; k < MAX_AGENTS; k++) begin
            if (k < n && en[k] && addrs[k] == a) w = k;
        end
        return w;
    endfunction

    function automatic entry_t make_entry(input logic coll, input int bank);
        entry_t e;
        e.coll = coll;
        e.bank = MAX_BANK_W'(bank);
        return e;
    endfunction

    // Flattens an entry into {coll, bank} with the flag just above the bank_w index bits.
    function automatic logic [MAX_SEL_W-1:0] pack_select(input entry_t e, input int bank_w, input int wc);
        logic [MAX_SEL_W-1:0] r;
        r = {1'b0, e.bank};
        if (wc != 0) r = r | (MAX_SEL_W'(e.coll) << bank_w);
        return r;
    endfunction

endpackage

// File: rtl/write_collision_detect.sv
// Per-agent same-address collision and winner (highest index per address) flags.
module write_collision_detect
    import meduram_pkg::*;
#(
    parameter int NB_WRAGENT = 2,
    parameter int ADDR_WIDTH = 8
) (
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
    output logic [NB_WRAGENT-1:0]            collision,
    output logic [NB_WRAGENT-1:0]            winner
);

    logic [MAX_AGENTS-1:0]                 en_ext;
    logic [MAX_AGENTS-1:0][MAX_ADDR_W-1:0] addr_ext;

    always_comb begin
        en_ext   = '0;
        addr_ext = '0;
        for (int k = 0; k < NB_WRAGENT; k++) begin
            en_ext[k]   = wren[k];
            addr_ext[k] = MAX_ADDR_W'(wraddr[k*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    always_comb begin
        collision = '0;
        winner    = '0;
        for (int k = 0; k < NB_WRAGENT; k++) begin
            if (wren[k]) begin
                for (int j = 0; j < NB_WRAGENT; j++) begin
                    if (j != k && wren[j] && addr_ext[j] == addr_ext[k]) collision[k] = 1'b1;
                end
                winner[k] = (highest_match(en_ext, addr_ext, addr_ext[k], NB_WRAGENT) == k);
            end
        end
    end

endmodule

// File: rtl/write_accounter.sv
// Registers write-agent requests to their banks and tracks, per address, which
// bank holds the latest data so the read switch can pick it.
module write_accounter
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int NB_WRAGENT      = 2,
    parameter int NB_RDAGENT      = 2,
    parameter int WRITE_COLLISION = 1,
    localparam int SELECT_WIDTH   = select_width(NB_WRAGENT, WRITE_COLLISION)
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [NB_WRAGENT-1:0]              m_wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   m_wraddr,
    input  logic [NB_WRAGENT*DATA_WIDTH-1:0]   m_wrdata,
    output logic [NB_WRAGENT-1:0]              s_wren,
    output logic [NB_WRAGENT*ADDR_WIDTH-1:0]   s_wraddr,
    output logic [NB_WRAGENT*DATA_WIDTH-1:0]   s_wrdata,
    output logic [NB_WRAGENT-1:0]              m_wrcollision,
    input  logic [NB_RDAGENT-1:0]              m_rden,
    input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_rdaddr,
    output logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select
);

    localparam int BANK_W = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    logic [NB_WRAGENT-1:0]   coll_in;
    logic [NB_WRAGENT-1:0]   unused_win_in;
    logic [NB_WRAGENT-1:0]   coll_s;
    logic [NB_WRAGENT-1:0]   win_s;
    logic [SELECT_WIDTH-1:0] new_entry [NB_WRAGENT];
    logic [SELECT_WIDTH-1:0] table_q   [DEPTH];
    logic [NB_RDAGENT-1:0]   unused_rden;

    // m_rden only qualifies bank_select downstream in the read switch.
    assign unused_rden = m_rden;

    write_collision_detect #(
        .NB_WRAGENT (NB_WRAGENT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_detect_in (
        .wren      (m_wren),
        .wraddr    (m_wraddr),
        .collision (coll_in),
        .winner    (unused_win_in)
    );

    write_collision_detect #(
        .NB_WRAGENT (NB_WRAGENT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_detect_s (
        .wren      (s_wren),
        .wraddr    (s_wraddr),
        .collision (coll_s),
        .winner    (win_s)
    );

    always_comb begin
        for (int k = 0; k < NB_WRAGENT; k++) begin
            new_entry[k] = SELECT_WIDTH'(pack_select(make_entry(coll_s[k], k), BANK_W, WRITE_COLLISION));
        end
    end

    // Table commits together with the bank write, so lookups below stay read-first.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s_wren        <= '0;
            s_wraddr      <= '0;
            s_wrdata      <= '0;
            m_wrcollision <= '0;
            for (int d = 0; d < DEPTH; d++) table_q[d] <= '0;
        end else begin
            s_wren        <= m_wren;
            s_wraddr      <= m_wraddr;
            s_wrdata      <= m_wrdata;
            m_wrcollision <= (WRITE_COLLISION != 0) ? coll_in : '0;
            for (int k = 0; k < NB_WRAGENT; k++) begin
                if (win_s[k]) table_q[s_wraddr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= new_entry[k];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NB_RDAGENT; r++) begin
            bank_select[r*SELECT_WIDTH +: SELECT_WIDTH] = table_q[m_rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

endmodule

// File: tb/tb_write_accounter.sv
// Scoreboard bench for write_accounter: directed scenarios followed by random traffic.
module tb_write_accounter;

    localparam int AW = 4;
    localparam int DW = 32;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [1:0]  m_wren = '0;
    logic [7:0]  m_wraddr = '0;
    logic [63:0] m_wrdata = '0;
    logic [1:0]  s_wren;
    logic [7:0]  s_wraddr;
    logic [63:0] s_wrdata;
    logic [1:0]  m_wrcollision;
    logic [1:0]  m_rden = '0;
    logic [7:0]  m_rdaddr = '0;
    logic [3:0]  bank_select;

    write_accounter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .NB_WRAGENT      (2),
        .NB_RDAGENT      (2),
        .WRITE_COLLISION (1)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .m_wren        (m_wren),
        .m_wraddr      (m_wraddr),
        .m_wrdata      (m_wrdata),
        .s_wren        (s_wren),
        .s_wraddr      (s_wraddr),
        .s_wrdata      (s_wrdata),
        .m_wrcollision (m_wrcollision),
        .m_rden        (m_rden),
        .m_rdaddr      (m_rdaddr),
        .bank_select   (bank_select)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int          cyc;
        logic [1:0]  en;
        logic [7:0]  addr;
        logic [63:0] data;
        logic [1:0]  coll;
    } wexp_t;

    typedef struct {
        int         cyc;
        logic [3:0] bs;
    } rexp_t;

    wexp_t wq[$];
    rexp_t rq[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = -1;

    // Reference model: what each address last saw, plus the writes in flight.
    logic [1:0]  tab [16];
    logic [1:0]  st_en = '0;
    logic [3:0]  st_a [2];
    logic [31:0] st_d [2];
    logic [1:0]  lst_en = '0;
    logic [3:0]  lst_a [2];
    logic [31:0] lst_d [2];
    bit          rst_prev = 1'b1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void commit_stage();
        for (int a = 0; a < 16; a++) begin
            int cnt;
            int hi;
            cnt = 0;
            hi  = 0;
            for (int k = 0; k < 2; k++) begin
                if (st_en[k] && st_a[k] == 4'(a)) begin
                    cnt++;
                    hi = k;
                end
            end
            if (cnt > 0) tab[a] = {logic'(cnt > 1), logic'(hi[0])};
        end
    endfunction

    function automatic logic [1:0] coll_of();
        logic [1:0] c;
        c = '0;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 2; j++)
                if (j != k && st_en[k] && st_en[j] && st_a[k] == st_a[j]) c[k] = 1'b1;
        return c;
    endfunction

    task automatic step(input logic [1:0] en, input logic [3:0] a0, input logic [3:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [3:0] r0, input logic [3:0] r1, input logic rn);
        @(posedge aclk);
        #1;
        cyc++;
        if (rst_prev) begin
            for (int a = 0; a < 16; a++) tab[a] = 2'b00;
            st_en = '0;
            st_a  = '{4'd0, 4'd0};
            st_d  = '{32'd0, 32'd0};
        end else begin
            commit_stage();
            st_en = lst_en;
            st_a  = lst_a;
            st_d  = lst_d;
        end
        wq.push_back('{cyc, st_en, {st_a[1], st_a[0]}, {st_d[1], st_d[0]}, coll_of()});
        m_wren   = en;
        m_wraddr = {a1, a0};
        m_wrdata = {d1, d0};
        m_rdaddr = {r1, r0};
        m_rden   = 2'($urandom_range(0, 3));
        aresetn  = rn;
        rq.push_back('{cyc, {tab[r1], tab[r0]}});
        lst_en   = en;
        lst_a    = '{a0, a1};
        lst_a[0] = a0;
        lst_a[1] = a1;
        lst_d[0] = d0;
        lst_d[1] = d1;
        rst_prev = !rn;
    endtask

    task automatic idle(input logic [3:0] r0, input logic [3:0] r1, input int n);
        for (int i = 0; i < n; i++) step(2'b00, 4'($urandom), 4'($urandom), $urandom, $urandom, r0, r1, 1'b1);
    endtask

    // Monitor: compares DUT outputs mid-cycle against queued expectations.
    initial begin
        forever begin
            @(negedge aclk);
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                wexp_t w;
                w = wq.pop_front();
                chk("s_wren", 64'(s_wren), 64'(w.en));
                chk("s_wraddr", 64'(s_wraddr), 64'(w.addr));
                chk("s_wrdata", s_wrdata, w.data);
                chk("m_wrcollision", 64'(m_wrcollision), 64'(w.coll));
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                rexp_t r;
                r = rq.pop_front();
                chk("bank_select", 64'(bank_select), 64'(r.bs));
            end
        end
    end

    initial begin
        for (int a = 0; a < 16; a++) tab[a] = 2'b00;
        st_a  = '{4'd0, 4'd0};
        st_d  = '{32'd0, 32'd0};
        lst_a = '{4'd0, 4'd0};
        lst_d = '{32'd0, 32'd0};
        // Reset, then idle reads of a never-written address.
        for (int i = 0; i < 3; i++) step(2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 4'd5, 4'd5, 1'b0);
        idle(4'd5, 4'd5, 2);
        // Single write by agent 1.
        step(2'b10, 4'd0, 4'd3, 32'h0, 32'hA5, 4'd3, 4'd3, 1'b1);
        idle(4'd3, 4'd3, 3);
        // Both agents on one address, then agent 0 alone clears the flag.
        step(2'b11, 4'd7, 4'd7, 32'h11, 32'h22, 4'd7, 4'd7, 1'b1);
        idle(4'd7, 4'd7, 2);
        step(2'b01, 4'd7, 4'd0, 32'h33, 32'h0, 4'd7, 4'd7, 1'b1);
        idle(4'd7, 4'd7, 3);
        // Different addresses in the same cycle.
        step(2'b11, 4'd2, 4'd9, 32'h44, 32'h55, 4'd2, 4'd9, 1'b1);
        idle(4'd2, 4'd9, 3);
        // Reset drops an in-flight write.
        step(2'b10, 4'd0, 4'd4, 32'h0, 32'h66, 4'd4, 4'd4, 1'b1);
        step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 4'd4, 4'd4, 1'b0);
        idle(4'd4, 4'd4, 3);
        // Ownership switch seen identically by both readers.
        step(2'b10, 4'd0, 4'd3, 32'h0, 32'h77, 4'd3, 4'd3, 1'b1);
        idle(4'd3, 4'd3, 2);
        step(2'b01, 4'd3, 4'd0, 32'h88, 32'h0, 4'd3, 4'd3, 1'b1);
        idle(4'd3, 4'd3, 3);
        // Random traffic on a narrow address range to provoke collisions.
        for (int i = 0; i < 600; i++) begin
            logic rn;
            rn = ($urandom_range(0, 49) != 0);
            step(2'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom, $urandom,
                 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), rn);
        end
        @(negedge aclk);
        #1;
        chk("queues_drained", 64'(wq.size() + rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
